// File: rtl/pc_sequencer.sv
// Program-counter register stage: BOOT/RUN/HALTED sequencing with a valid/ready fetch handshake.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] pc_out,
   input  logic [WIDTH-1:0] pc_inc,
   output logic             fetch_valid,
   input  logic             fetch_ready,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             halt,
   input  logic             resume,
`ifdef PC_RAS_EN
   input  logic             call,
   input  logic             ret,
   output logic             ras_empty,
   output logic             ras_full,
`endif
   output logic             halted
);

   typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pc_nxt;

`ifdef PC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    wp, top_idx;
   logic [PW:0]      cnt;
   logic             push, pop;

   // wp points at the next free slot; the stack wraps so a push when full overwrites the oldest
   assign top_idx   = (wp == '0) ? PW'(RAS_DEPTH - 1) : wp - 1'b1;
   assign ras_empty = (cnt == '0);
   assign ras_full  = (cnt == (PW+1)'(RAS_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      end else if (push) begin
         ras_mem[wp] <= pc_inc;
         wp          <= (wp == PW'(RAS_DEPTH - 1)) ? '0 : wp + 1'b1;
         if (!ras_full) cnt <= cnt + 1'b1;
      end else if (pop && !ras_empty) begin
         wp  <= top_idx;
         cnt <= cnt - 1'b1;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_out;
`ifdef PC_RAS_EN
      push      = 1'b0;
      pop       = 1'b0;
`endif
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (halt) begin
               state_nxt = HALTED;
`ifdef PC_RAS_EN
            end else if (ret) begin
               pop    = 1'b1;
               pc_nxt = ras_empty ? RESET_VECTOR : ras_mem[top_idx];
            end else if (call) begin
               push   = 1'b1;
               pc_nxt = jump_target;
`endif
            end else if (jump) begin
               pc_nxt = jump_target;
            end else if (branch_taken) begin
               pc_nxt = branch_target;
            end else if (fetch_ready && !stall) begin
               // fetch_valid is implied by RUN, so this is the accept
               pc_nxt = pc_inc;
            end
         end
         HALTED: if (resume) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= BOOT;
         pc_out <= RESET_VECTOR;
      end else begin
         state  <= state_nxt;
         pc_out <= pc_nxt;
      end
   end

   assign fetch_valid = (state == RUN);
   assign halted      = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences, and random
// stimulus against a rule-level reference model. RAS checks are built when PC_RAS_EN is defined.
module tb_pc_sequencer;
   localparam int          W  = 16;
   localparam logic [15:0] RV = 16'h0000;
   localparam int          D  = 4;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [W-1:0]  pc_out, pc_inc, branch_target, jump_target;
   logic          fetch_valid, fetch_ready, stall, branch_taken, jump, halt, resume, halted;
`ifdef PC_RAS_EN
   logic          call, ret, ras_empty, ras_full;
`endif

   int checks = 0, errors = 0;

   assign pc_inc = pc_out + 16'd1;
   always #5 clk = ~clk;

   pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV), .RAS_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .pc_inc(pc_inc),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .halt(halt), .resume(resume),
`ifdef PC_RAS_EN
      .call(call), .ret(ret), .ras_empty(ras_empty), .ras_full(ras_full),
`endif
      .halted(halted));

   typedef struct {
      logic st, rdy, br; logic [15:0] bt;
      logic jmp; logic [15:0] jt;
      logic hl, rs, cl, rt;
      logic [15:0] e_pc; logic e_fv, e_h;
   } vec_t;

   function automatic vec_t mk(logic st, logic rdy, logic br, logic [15:0] bt, logic jmp,
                               logic [15:0] jt, logic hl, logic rs,
                               logic [15:0] epc, logic efv, logic eh);
      vec_t v;
      v.st = st; v.rdy = rdy; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
      v.hl = hl; v.rs = rs; v.cl = 1'b0; v.rt = 1'b0;
      v.e_pc = epc; v.e_fv = efv; v.e_h = eh;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      stall = v.st; fetch_ready = v.rdy; branch_taken = v.br; branch_target = v.bt;
      jump = v.jmp; jump_target = v.jt; halt = v.hl; resume = v.rs;
`ifdef PC_RAS_EN
      call = v.cl; ret = v.rt;
`endif
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      drive(v); step;
      chk({name, ".pc"}, 32'(pc_out), 32'(v.e_pc));
      chk({name, ".fv"}, 32'(fetch_valid), 32'(v.e_fv));
      chk({name, ".halted"}, 32'(halted), 32'(v.e_h));
   endtask

   task automatic do_reset;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0));
      rst_n = 1'b0; #2;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   vec_t vt[25];

   initial begin
      vt[0]  = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0000,1,0); // BOOT -> RUN, pc held
      vt[1]  = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0001,1,0);
      vt[2]  = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0002,1,0);
      vt[3]  = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0003,1,0);
      vt[4]  = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0004,1,0);
      vt[5]  = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0005,1,0);
      vt[6]  = mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0005,1,0); // not ready x3
      vt[7]  = mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0005,1,0);
      vt[8]  = mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0005,1,0);
      vt[9]  = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0006,1,0);
      vt[10] = mk(0,1,0,16'h0000,1,16'h0010,0,0, 16'h0010,1,0);
      vt[11] = mk(1,1,1,16'h0040,0,16'h0000,0,0, 16'h0040,1,0); // branch beats stall
      vt[12] = mk(1,1,0,16'h0000,0,16'h0000,0,0, 16'h0040,1,0); // stall holds
      vt[13] = mk(0,1,1,16'h0040,1,16'h0080,0,0, 16'h0080,1,0); // jump beats branch
      vt[14] = mk(0,1,0,16'h0000,1,16'hFFFF,0,0, 16'hFFFF,1,0);
      vt[15] = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0000,1,0); // wrap
      vt[16] = mk(0,1,0,16'h0000,1,16'h0020,0,0, 16'h0020,1,0);
      vt[17] = mk(0,1,0,16'h0000,0,16'h0000,1,0, 16'h0020,0,1); // halt beats advance
      vt[18] = mk(0,1,1,16'h0040,1,16'h1234,0,0, 16'h0020,0,1); // ignored while halted
      vt[19] = mk(0,1,0,16'h0000,0,16'h0000,1,1, 16'h0020,1,0); // resume wins over halt
      vt[20] = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0021,1,0);
      vt[21] = mk(0,1,0,16'h0000,0,16'h0000,1,0, 16'h0021,0,1);
      vt[22] = mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0021,0,1);
      vt[23] = mk(0,1,0,16'h0000,0,16'h0000,0,1, 16'h0021,1,0);
      vt[24] = mk(0,0,1,16'h0300,0,16'h0000,0,0, 16'h0300,1,0); // redirect without ready

      drive(mk(0,0,0,0,0,0,0,0,0,0,0));
      #12;
      chk("reset.pc", 32'(pc_out), 32'(RV));
      chk("reset.fv", 32'(fetch_valid), 32'd0);
      chk("reset.halted", 32'(halted), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 25; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // asynchronous reset mid-run, no clock edge needed
      #2 rst_n = 1'b0; #1;
      chk("midreset.pc", 32'(pc_out), 32'(RV));
      chk("midreset.fv", 32'(fetch_valid), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

`ifdef PC_RAS_EN
      begin
         vec_t v;
         logic [15:0] rets [4] = '{16'h0601, 16'h0501, 16'h0401, 16'h0301};
         chk("ras.reset_empty", 32'(ras_empty), 32'd1);
         run_vec(mk(0,0,0,0,0,0,0,0, 16'h0000,1,0), "ras.boot");
         run_vec(mk(0,0,0,0,1,16'h0010,0,0, 16'h0010,1,0), "ras.j10");
         v = mk(0,1,0,0,0,16'h0100,0,0, 16'h0100,1,0); v.cl = 1'b1;
         run_vec(v, "ras.call");
         chk("ras.nonempty", 32'(ras_empty), 32'd0);
         v = mk(0,1,0,0,0,16'h0000,0,0, 16'h0011,1,0); v.rt = 1'b1; v.cl = 1'b1;
         run_vec(v, "ras.ret");                       // ret beats call, no push
         chk("ras.empty_after_ret", 32'(ras_empty), 32'd1);
         run_vec(mk(0,0,0,0,1,16'h0200,0,0, 16'h0200,1,0), "ras.j200");
         for (int k = 0; k < 5; k++) begin
            v = mk(0,1,0,0,0,16'h0300 + 16'(k*256),0,0, 16'h0300 + 16'(k*256),1,0);
            v.cl = 1'b1;
            run_vec(v, $sformatf("ras.call%0d", k));
         end
         chk("ras.full", 32'(ras_full), 32'd1);
         for (int k = 0; k < 4; k++) begin
            v = mk(0,1,0,0,0,0,0,0, rets[k],1,0); v.rt = 1'b1;
            run_vec(v, $sformatf("ras.ret%0d", k));
         end
         chk("ras.drained", 32'(ras_empty), 32'd1);
         v = mk(0,1,0,0,0,0,0,0, RV,1,0); v.rt = 1'b1;
         run_vec(v, "ras.ret_empty");
         chk("ras.still_empty", 32'(ras_empty), 32'd1);
      end
`endif

      // random stimulus vs. rule model
      do_reset;
      begin
         int mode = 0;                // 0 boot, 1 run, 2 halted
         logic [15:0] mpc = RV;
         logic [15:0] q[$];
         vec_t v;
         for (int n = 0; n < 2000; n++) begin
            v.st  = ($urandom_range(3) == 0);
            v.rdy = ($urandom_range(3) != 0);
            v.br  = ($urandom_range(7) == 0);
            v.bt  = 16'($urandom);
            v.jmp = ($urandom_range(9) == 0);
            v.jt  = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            v.hl  = ($urandom_range(15) == 0);
            v.rs  = ($urandom_range(3) == 0);
`ifdef PC_RAS_EN
            v.cl  = ($urandom_range(7) == 0);
            v.rt  = ($urandom_range(7) == 0);
`else
            v.cl  = 1'b0;
            v.rt  = 1'b0;
`endif
            if (mode == 0) mode = 1;
            else if (mode == 2) begin
               if (v.rs) mode = 1;
            end else if (v.hl) mode = 2;
            else if (v.rt) begin
               if (q.size() > 0) mpc = q.pop_back();
               else mpc = RV;
            end else if (v.cl) begin
               q.push_back(mpc + 16'd1);
               if (q.size() > D) void'(q.pop_front());
               mpc = v.jt;
            end else if (v.jmp) mpc = v.jt;
            else if (v.br) mpc = v.bt;
            else if (v.rdy && !v.st) mpc = mpc + 16'd1;
            v.e_pc = mpc; v.e_fv = (mode == 1); v.e_h = (mode == 2);
            run_vec(v, $sformatf("rnd%0d", n));
`ifdef PC_RAS_EN
            chk($sformatf("rnd%0d.empty", n), 32'(ras_empty), 32'(q.size() == 0));
            chk($sformatf("rnd%0d.full", n), 32'(ras_full), 32'(q.size() == D));
`endif
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
